// File: rtl/tcp_checksum_arbiter_pkg.sv
// tcp_checksum_arbiter_pkg: shared FSM encoding, tag FIFO depth and round-robin pick
//   state_t  : arbiter FSM states
//   TAG_DEPTH: outstanding packets tracked, equal to the engine result FIFO depth
//   rr_pick  : first valid requester at or after ptr, wrapping modulo n (n <= 4)
package tcp_checksum_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    localparam int TAG_DEPTH = 4;

    function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr, input int n);
        logic [1:0] idx;
        logic found;
        rr_pick = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = 2'((int'(ptr) + k) % n);
            if (!found && k < n && valid[idx]) begin
                rr_pick = idx;
                found = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small first-word-fall-through FIFO
//   din/wr_en : write side, writes while full are dropped
//   dout/rd_en: head word is visible on dout whenever empty=0, rd_en pops it
//   empty     : no stored words
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = MAX_DEPTH_BITS;
    localparam int CW = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0] mem_q [1 << AW];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr, rd;

    always_comb begin
        // the count MSB is set exactly when the FIFO holds 2**AW words
        wr = wr_en && !cnt_q[AW];
        rd = rd_en && cnt_q != '0;
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        cnt_d = cnt_q + CW'(wr) - CW'(rd);
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = cnt_q == '0;

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/tcp_checksum_arbiter.sv
// tcp_checksum_arbiter: round-robin share of one tcp_checksum engine between NUM_REQ streams
//   req_*    : per-requester AXI-Stream beats and header flags, req_ready grants whole packets
//   eng_*    : muxed beat to the engine (no backpressure), ENG_GAP idle cycles after each tlast
//   eng_cksm*: engine result FIFO head, popped with eng_rd_cksm
//   res_*    : result routed to the requester that owns the oldest outstanding tag
//   err_orphan: sticky, a result arrived while no packet was outstanding
module tcp_checksum_arbiter
    import tcp_checksum_arbiter_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_REQ              = 2,
    parameter int ENG_GAP              = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ*C_S_AXIS_DATA_WIDTH-1:0]   req_tdata,
    input  logic [NUM_REQ*C_S_AXIS_DATA_WIDTH/8-1:0] req_tkeep,
    input  logic [NUM_REQ*C_S_AXIS_TUSER_WIDTH-1:0]  req_tuser,
    input  logic [NUM_REQ-1:0]                    req_tlast,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0]                    req_word_ip_dst_hi,
    input  logic [NUM_REQ-1:0]                    req_word_ip_dst_lo,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]        eng_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]      eng_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]       eng_tuser,
    output logic                                  eng_tlast,
    output logic                                  eng_valid,
    output logic                                  eng_word_IP_DST_HI,
    output logic                                  eng_word_IP_DST_LO,
    input  logic                                  eng_cksm_vld,
    input  logic [15:0]                           eng_cksm,
    output logic                                  eng_rd_cksm,
    output logic [NUM_REQ-1:0]                    res_vld,
    output logic [15:0]                           res_cksm,
    input  logic [NUM_REQ-1:0]                    res_rd,
    output logic                                  err_orphan
);
    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int KW    = DW / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int TAG_W = $clog2(NUM_REQ);

    state_t           state_q, state_d;
    logic [TAG_W-1:0] gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, tag_head;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [2:0]       tag_cnt_q, tag_cnt_d;
    logic             err_orphan_q, err_orphan_d;
    logic             beat, push, pop, tag_empty, res_live;

    always_comb begin
        beat = state_q == XFER && req_valid[gnt_q];
        push = beat && req_tlast[gnt_q];
        pop = eng_cksm_vld && !tag_empty && res_rd[tag_head];
        state_d = state_q;
        gnt_d = gnt_q;
        rr_ptr_d = rr_ptr_q;
        gap_cnt_d = (state_q == GAP) ? gap_cnt_q + 4'd1 : 4'd0;
        tag_cnt_d = tag_cnt_q + 3'(push) - 3'(pop);
        err_orphan_d = err_orphan_q || (eng_cksm_vld && tag_empty);
        // a new packet may start only while a result slot is free in the engine
        if (state_q == IDLE && |req_valid && tag_cnt_q < 3'(TAG_DEPTH)) begin
            state_d = XFER;
            gnt_d = TAG_W'(rr_pick(4'(req_valid), 2'(rr_ptr_q), NUM_REQ));
        end
        if (push) begin
            state_d = GAP;
            rr_ptr_d = (gnt_q == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end
        if (state_q == GAP && gap_cnt_q == 4'(ENG_GAP - 1)) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            rr_ptr_q     <= '0;
            gap_cnt_q    <= '0;
            tag_cnt_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_ptr_q     <= rr_ptr_d;
            gap_cnt_q    <= gap_cnt_d;
            tag_cnt_q    <= tag_cnt_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (TAG_W),
        .MAX_DEPTH_BITS (2)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (gnt_q),
        .wr_en (push),
        .rd_en (pop),
        .dout  (tag_head),
        .empty (tag_empty)
    );

    assign req_ready          = (state_q == XFER) ? NUM_REQ'(1'b1) << gnt_q : '0;
    assign eng_tdata          = req_tdata[gnt_q*DW +: DW];
    assign eng_tkeep          = req_tkeep[gnt_q*KW +: KW];
    assign eng_tuser          = req_tuser[gnt_q*UW +: UW];
    assign eng_tlast          = req_tlast[gnt_q] && beat;
    assign eng_valid          = beat;
    assign eng_word_IP_DST_HI = req_word_ip_dst_hi[gnt_q] && beat;
    assign eng_word_IP_DST_LO = req_word_ip_dst_lo[gnt_q] && beat;
    // with no outstanding tag the result is flushed and never offered to a requester
    assign res_live           = eng_cksm_vld && !tag_empty;
    assign res_vld            = res_live ? NUM_REQ'(1'b1) << tag_head : '0;
    assign res_cksm           = res_live ? eng_cksm : 16'h0;
    assign eng_rd_cksm        = eng_cksm_vld && (tag_empty || res_rd[tag_head]);
    assign err_orphan         = err_orphan_q;

endmodule

// File: tb/tb_tcp_checksum_arbiter.sv
// tb_tcp_checksum_arbiter: directed vector table plus hand sequences for tcp_checksum_arbiter
module tb_tcp_checksum_arbiter;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam int GAPC = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2*DW-1:0]  req_tdata = '0;
    logic [2*KW-1:0]  req_tkeep = '0;
    logic [2*UW-1:0]  req_tuser = '0;
    logic [1:0]       req_tlast = '0, req_valid = '0, req_ready;
    logic [1:0]       req_word_ip_dst_hi = '0, req_word_ip_dst_lo = '0;
    logic [DW-1:0]    eng_tdata;
    logic [KW-1:0]    eng_tkeep;
    logic [UW-1:0]    eng_tuser;
    logic             eng_tlast, eng_valid, eng_word_IP_DST_HI, eng_word_IP_DST_LO;
    logic             eng_cksm_vld = 1'b0;
    logic [15:0]      eng_cksm = '0;
    logic             eng_rd_cksm;
    logic [1:0]       res_vld;
    logic [15:0]      res_cksm;
    logic [1:0]       res_rd = '0;
    logic             err_orphan;

    tcp_checksum_arbiter #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .NUM_REQ              (2),
        .ENG_GAP              (GAPC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_tdata          (req_tdata),
        .req_tkeep          (req_tkeep),
        .req_tuser          (req_tuser),
        .req_tlast          (req_tlast),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_word_ip_dst_hi (req_word_ip_dst_hi),
        .req_word_ip_dst_lo (req_word_ip_dst_lo),
        .eng_tdata          (eng_tdata),
        .eng_tkeep          (eng_tkeep),
        .eng_tuser          (eng_tuser),
        .eng_tlast          (eng_tlast),
        .eng_valid          (eng_valid),
        .eng_word_IP_DST_HI (eng_word_IP_DST_HI),
        .eng_word_IP_DST_LO (eng_word_IP_DST_LO),
        .eng_cksm_vld       (eng_cksm_vld),
        .eng_cksm           (eng_cksm),
        .eng_rd_cksm        (eng_rd_cksm),
        .res_vld            (res_vld),
        .res_cksm           (res_cksm),
        .res_rd             (res_rd),
        .err_orphan         (err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v;
        int         bt;
        logic       last, hi, lo, cv;
        logic [1:0] rd;
        logic [1:0] e_rdy;
        logic       e_ev, e_hi, e_lo, e_last;
        logic [1:0] e_rv;
        logic       e_rdc;
    } vec_t;

    vec_t tbl [12];

    int ncmp = 0, nerr = 0;
    int cyc = 0, ntl = 0, ntot = 0, nb = 2, mptr = 0, last_tl = -1;
    int pk_left [2] = '{0, 0};
    int bcnt [2] = '{0, 0};
    logic en = 1'b0, pot = 1'b0, orph = 1'b0, gap_exact = 1'b0, force_now = 1'b0, seen;
    logic [1:0] rdmask = '0;
    int qt [$], qs [$];
    logic [15:0] qv [$];

    function automatic logic [DW-1:0] pat(int r, int b);
        return {8{8'(r + 1), 8'(b), 16'hA5C3}};
    endfunction

    function automatic logic [KW-1:0] kp(int r);
        return (r == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [UW-1:0] usr(int r, int b);
        return {8{8'(r + 5), 8'(b)}};
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(int r, logic v, int b, logic l, logic h, logic lo);
        req_tdata[r*DW +: DW] = pat(r, b);
        req_tkeep[r*KW +: KW] = kp(r);
        req_tuser[r*UW +: UW] = usr(r, b);
        req_valid[r] = v;
        req_tlast[r] = l;
        req_word_ip_dst_hi[r] = h;
        req_word_ip_dst_lo[r] = lo;
    endtask

    // one clock of the requester/engine model: drive at negedge, observe 1 ns later
    task automatic cycle();
        int g, ex;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            drive(i, pk_left[i] > 0, bcnt[i], bcnt[i] == nb - 1, bcnt[i] == 0, bcnt[i] == 1);
        force_now = pot && req_valid[0] && req_tlast[0];
        eng_cksm_vld = orph || (qt.size() > 0 && ((en && cyc >= qs[0]) || force_now));
        eng_cksm = orph ? 16'hDEAD : (qt.size() > 0 ? qv[0] : 16'h0);
        res_rd = rdmask;
        #1;
        if (eng_rd_cksm && !orph) begin
            if (qt.size() == 0) chk("spurious_rd", 1'b1, 1'b0);
            else begin
                chk("res_vld", res_vld, 2'b01 << qt[0]);
                chk("res_cksm", res_cksm, qv[0]);
                void'(qt.pop_front());
                void'(qs.pop_front());
                void'(qv.pop_front());
                if (force_now) pot = 1'b0;
            end
        end
        if (eng_valid) begin
            ex = (pk_left[mptr] > 0) ? mptr : 1 - mptr;
            chk("grant", req_ready, 2'b01 << ex);
            g = int'(req_ready[1]);
            if (bcnt[g] == 0 && gap_exact && last_tl >= 0) chk("gap_len", cyc - last_tl, GAPC + 2);
            chk("eng_tdata", eng_tdata, pat(g, bcnt[g]));
            chk("eng_tkeep", eng_tkeep, kp(g));
            chk("eng_tuser", eng_tuser, usr(g, bcnt[g]));
            chk("eng_hi", eng_word_IP_DST_HI, bcnt[g] == 0);
            chk("eng_lo", eng_word_IP_DST_LO, bcnt[g] == 1);
            chk("eng_tlast", eng_tlast, bcnt[g] == nb - 1);
            if (bcnt[g] == nb - 1) begin
                ntl++;
                ntot++;
                qt.push_back(g);
                qs.push_back(cyc + 5);
                qv.push_back(16'h1000 + 16'(ntot));
                mptr = 1 - g;
                last_tl = cyc;
                pk_left[g]--;
                bcnt[g] = 0;
            end else bcnt[g]++;
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            v     bt last hi lo cv rd    | rdy   ev hi lo last rv    rdc
        tbl[0]  = '{2'b10, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0};
        tbl[1]  = '{2'b10, 0, 0, 1, 0, 0, 2'b00, 2'b10, 1, 1, 0, 0, 2'b00, 0};
        tbl[2]  = '{2'b10, 1, 0, 0, 1, 0, 2'b00, 2'b10, 1, 0, 1, 0, 2'b00, 0};
        tbl[3]  = '{2'b10, 2, 1, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0, 1, 2'b00, 0};
        tbl[4]  = '{2'b00, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0};
        tbl[5]  = '{2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0};
        tbl[6]  = '{2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0};
        tbl[7]  = '{2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0};
        tbl[8]  = '{2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 0};
        tbl[9]  = '{2'b00, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b10, 0};
        tbl[10] = '{2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 2'b10, 1};
        tbl[11] = '{2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0};

        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_eng_valid", eng_valid, 1'b0);
        chk("rst_res_vld", res_vld, 2'b00);
        chk("rst_rd_cksm", eng_rd_cksm, 1'b0);
        chk("rst_orphan", err_orphan, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1, tbl[i].v[1], tbl[i].bt, tbl[i].last, tbl[i].hi, tbl[i].lo);
            drive(0, tbl[i].v[0], 0, 0, 0, 0);
            eng_cksm_vld = tbl[i].cv;
            eng_cksm = 16'h1C46;
            res_rd = tbl[i].rd;
            #1;
            chk($sformatf("t%0d_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("t%0d_eng_valid", i), eng_valid, tbl[i].e_ev);
            chk($sformatf("t%0d_eng_hi", i), eng_word_IP_DST_HI, tbl[i].e_hi);
            chk($sformatf("t%0d_eng_lo", i), eng_word_IP_DST_LO, tbl[i].e_lo);
            chk($sformatf("t%0d_eng_tlast", i), eng_tlast, tbl[i].e_last);
            chk($sformatf("t%0d_res_vld", i), res_vld, tbl[i].e_rv);
            chk($sformatf("t%0d_res_cksm", i), res_cksm, (tbl[i].e_rv != 2'b00) ? 16'h1C46 : 16'h0);
            chk($sformatf("t%0d_rd_cksm", i), eng_rd_cksm, tbl[i].e_rdc);
            if (tbl[i].e_ev) begin
                chk($sformatf("t%0d_tdata", i), eng_tdata, pat(1, tbl[i].bt));
                chk($sformatf("t%0d_tuser", i), eng_tuser, usr(1, tbl[i].bt));
                chk($sformatf("t%0d_tkeep", i), eng_tkeep, kp(1));
            end
        end

        // round robin with both requesters streaming, results returned continuously
        mptr = 0; last_tl = -1; ntl = 0;
        pk_left = '{4, 4}; nb = 2; en = 1'b1; rdmask = 2'b11; gap_exact = 1'b1;
        for (int k = 0; k < 400 && !(pk_left[0] + pk_left[1] == 0 && qt.size() == 0); k++) cycle();
        chk("A_done", pk_left[0] + pk_left[1] + qt.size(), 0);
        chk("A_packets", ntl, 8);

        // results stalled: the fifth packet must wait for a free tag
        gap_exact = 1'b0; en = 1'b0; rdmask = 2'b01; ntl = 0; pk_left[0] = 6;
        for (int k = 0; k < 60; k++) cycle();
        chk("B_tlasts", ntl, 4);
        chk("B_blocked", req_ready, 2'b00);
        en = 1'b1;
        cycle();
        en = 1'b0;
        chk("B_popped", qt.size(), 3);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            seen = seen | req_ready[0];
        end
        chk("B_regrant", seen, 1'b1);
        en = 1'b1;
        for (int k = 0; k < 200 && !(pk_left[0] == 0 && qt.size() == 0); k++) cycle();
        chk("B_done", pk_left[0] + qt.size(), 0);

        // push and pop in the same cycle at three outstanding tags
        en = 1'b0; ntl = 0; pk_left[0] = 3;
        for (int k = 0; k < 60 && ntl < 3; k++) cycle();
        chk("C_three", ntl, 3);
        pk_left[0] = 3; pot = 1'b1;
        for (int k = 0; k < 40 && ntl < 4; k++) cycle();
        chk("C_same_cycle_pop", pot, 1'b0);
        for (int k = 0; k < 30 && ntl < 5; k++) cycle();
        chk("C_not_blocked", ntl, 5);
        for (int k = 0; k < 20; k++) cycle();
        chk("C_full_tlasts", ntl, 5);
        chk("C_full_blocked", req_ready, 2'b00);
        en = 1'b1;
        for (int k = 0; k < 200 && !(pk_left[0] == 0 && qt.size() == 0); k++) cycle();
        chk("C_done", pk_left[0] + qt.size(), 0);

        // orphan result with no outstanding packet
        orph = 1'b1;
        cycle();
        chk("D_flush", eng_rd_cksm, 1'b1);
        chk("D_res_vld", res_vld, 2'b00);
        chk("D_res_cksm", res_cksm, 16'h0);
        chk("D_orphan_pre", err_orphan, 1'b0);
        orph = 1'b0;
        cycle();
        chk("D_orphan_set", err_orphan, 1'b1);
        for (int k = 0; k < 5; k++) cycle();
        chk("D_orphan_sticky", err_orphan, 1'b1);
        chk("D_no_rd", eng_rd_cksm, 1'b0);

        // asynchronous reset in the middle of a 4-beat packet
        nb = 4; pk_left[0] = 1;
        for (int k = 0; k < 20 && bcnt[0] != 2; k++) cycle();
        chk("E_mid", bcnt[0], 2);
        @(negedge clk);
        drive(0, 1'b1, 2, 1'b0, 1'b1, 1'b1);
        #1;
        chk("E_pre_valid", eng_valid, 1'b1);
        chk("E_pre_hi", eng_word_IP_DST_HI, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("E_rst_ready", req_ready, 2'b00);
        chk("E_rst_valid", eng_valid, 1'b0);
        chk("E_rst_hi", eng_word_IP_DST_HI, 1'b0);
        chk("E_rst_lo", eng_word_IP_DST_LO, 1'b0);
        chk("E_rst_res_vld", res_vld, 2'b00);
        chk("E_rst_rd_cksm", eng_rd_cksm, 1'b0);
        chk("E_rst_orphan", err_orphan, 1'b0);
        drive(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        qt.delete(); qs.delete(); qv.delete();
        pk_left = '{1, 1}; bcnt = '{0, 0}; nb = 2; mptr = 0; last_tl = -1;
        en = 1'b1; rdmask = 2'b11; ntl = 0;
        cycle();
        chk("E_idle", req_ready, 2'b00);
        cycle();
        chk("E_rr_first", req_ready, 2'b01);
        for (int k = 0; k < 100 && !(pk_left[0] + pk_left[1] == 0 && qt.size() == 0); k++) cycle();
        chk("E_done", pk_left[0] + pk_left[1] + qt.size(), 0);
        chk("E_packets", ntl, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
